xc_malu_seq: RTL and testbench

Sequencer that owns the iterative state of the multi-cycle ALU datapath (mul/div/rem/pmul step logic) and drives it one step per cycle. Accepts one operation at a time from the CPU through a valid/ready request channel. Holds operands, `count`, `acc`, `arg_0` and `arg_1` in registers, and feeds the datapath's next-state values back in until the datapath signals completion. Returns the 64-bit result through a valid/ready response channel.

---
 rtl/xc_malu_seq_pkg.sv | 26 ++
 rtl/xc_malu_seq_fsm.sv | 90 +++++++++
 rtl/xc_malu_seq.sv | 98 +++++++++
 tb/tb_xc_malu_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/xc_malu_seq_pkg.sv
// Shared encodings for the multi-cycle ALU sequencer: op codes, FSM states, step-count limits.
package xc_malu_pkg;

  localparam int XC_MALU_COUNT_W = 6;
  localparam logic [XC_MALU_COUNT_W-1:0] XC_MALU_COUNT_MAX = 6'd63;

  typedef enum logic [3:0] {
    OP_DIV    = 4'd0,
    OP_DIVU   = 4'd1,
    OP_REM    = 4'd2,
    OP_REMU   = 4'd3,
    OP_MUL    = 4'd4,
    OP_MULU   = 4'd5,
    OP_MULSU  = 4'd6,
    OP_CLMUL  = 4'd7,
    OP_PMUL   = 4'd8,
    OP_PCLMUL = 4'd9
  } malu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } malu_state_t;

endpackage

// File: rtl/xc_malu_seq_fsm.sv
// Control half of the ALU sequencer: state, step count, flush pulse and step timeout.
// Define XC_MALU_SEQ_TIMEOUT_EN to end a run with rsp_error once count reaches its maximum.
module xc_malu_seq_fsm
  import xc_malu_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       req_valid,
  input  logic                       st_ready,
  input  logic                       rsp_ready,
  output logic                       req_ready,
  output logic                       st_valid,
  output logic                       st_flush,
  output logic [XC_MALU_COUNT_W-1:0] count,
  output logic                       rsp_valid,
  output logic                       rsp_error,
  output logic                       load,
  output logic                       step,
  output logic                       finish,
  output logic                       expire
);

  malu_state_t state;
  logic        timeout;

`ifdef XC_MALU_SEQ_TIMEOUT_EN
  assign timeout = !st_ready && (count == XC_MALU_COUNT_MAX);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: req_ready is the one combinational output; it must drop in the same cycle flush is raised.
  assign req_ready = (state == S_IDLE) && !flush;

  assign load   = req_valid && req_ready;
  assign finish = (state == S_RUN) && !flush && st_ready;
  assign expire = (state == S_RUN) && !flush && timeout;
  assign step   = (state == S_RUN) && !flush && !st_ready && !timeout;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      st_valid  <= 1'b0;
      st_flush  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
    end else begin
      st_flush <= flush;
      if (flush) begin
        state     <= S_IDLE;
        count     <= '0;
        st_valid  <= 1'b0;
        rsp_valid <= 1'b0;
        rsp_error <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (req_valid) begin
              state     <= S_RUN;
              count     <= '0;
              st_valid  <= 1'b1;
              rsp_error <= 1'b0;
            end
          end
          S_RUN: begin
            if (st_ready || timeout) begin
              state     <= S_DONE;
              st_valid  <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_error <= timeout;
            end else if (count != XC_MALU_COUNT_MAX) begin
              count <= count + 1'b1;
            end
          end
          S_DONE: begin
            if (rsp_ready) begin
              state     <= S_IDLE;
              rsp_valid <= 1'b0;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/xc_malu_seq.sv
// Multi-cycle ALU sequencer top: operand/step-state registers around xc_malu_seq_fsm.
// Optional step timeout is enabled by defining XC_MALU_SEQ_TIMEOUT_EN.
module xc_malu_seq
  import xc_malu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  output logic        st_valid,
  output logic        st_flush,
  output logic [3:0]  st_op,
  output logic [31:0] st_rs1,
  output logic [31:0] st_rs2,
  output logic [31:0] st_rs3,
  output logic [5:0]  st_count,
  output logic [63:0] st_acc,
  output logic [31:0] st_arg_0,
  output logic [31:0] st_arg_1,
  input  logic [63:0] st_n_acc,
  input  logic [31:0] st_n_arg_0,
  input  logic [31:0] st_n_arg_1,
  input  logic        st_ready,
  input  logic [63:0] st_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_error
);

  malu_op_t op;
  logic     load, step, finish, expire;

  xc_malu_seq_fsm u_fsm (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .st_ready  (st_ready),
    .rsp_ready (rsp_ready),
    .req_ready (req_ready),
    .st_valid  (st_valid),
    .st_flush  (st_flush),
    .count     (st_count),
    .rsp_valid (rsp_valid),
    .rsp_error (rsp_error),
    .load      (load),
    .step      (step),
    .finish    (finish),
    .expire    (expire)
  );

  assign st_op = op;

  // NOTE: these are plain registers, not memories, so every one gets a reset value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op         <= OP_DIV;
      st_rs1     <= '0;
      st_rs2     <= '0;
      st_rs3     <= '0;
      st_acc     <= '0;
      st_arg_0   <= '0;
      st_arg_1   <= '0;
      rsp_result <= '0;
    end else begin
      if (flush) begin
        st_acc   <= '0;
        st_arg_0 <= '0;
        st_arg_1 <= '0;
      end else if (load) begin
        op       <= malu_op_t'(req_op);
        st_rs1   <= req_rs1;
        st_rs2   <= req_rs2;
        st_rs3   <= req_rs3;
        st_acc   <= '0;
        st_arg_0 <= '0;
        st_arg_1 <= '0;
      end else if (step) begin
        st_acc   <= st_n_acc;
        st_arg_0 <= st_n_arg_0;
        st_arg_1 <= st_n_arg_1;
      end

      // A timed-out run reports a zero result alongside rsp_error.
      if (finish)
        rsp_result <= st_result;
      else if (expire)
        rsp_result <= '0;
    end
  end

endmodule

// File: tb/tb_xc_malu_seq.sv
// Directed bench for xc_malu_seq with a simple step model driving the datapath inputs.
module tb_xc_malu_seq;
  import xc_malu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic        st_valid, st_flush;
  logic [3:0]  st_op;
  logic [31:0] st_rs1, st_rs2, st_rs3;
  logic [5:0]  st_count;
  logic [63:0] st_acc;
  logic [31:0] st_arg_0, st_arg_1;
  logic [63:0] st_n_acc;
  logic [31:0] st_n_arg_0, st_n_arg_1;
  logic        st_ready;
  logic [63:0] st_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_result;
  logic        rsp_error;

  // Step model: acc grows by 3 per step, arg_0 counts steps, ready fires at a chosen count.
  logic        ready_en = 1'b0;
  logic [5:0]  ready_at = 6'd0;
  logic [63:0] res_val = '0;

  assign st_n_acc   = st_acc + 64'd3;
  assign st_n_arg_0 = st_arg_0 + 32'd1;
  assign st_n_arg_1 = st_arg_1 + 32'd2;
  assign st_ready   = ready_en && st_valid && (st_count == ready_at);
  assign st_result  = res_val;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  xc_malu_seq dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rs3    (req_rs3),
    .st_valid   (st_valid),
    .st_flush   (st_flush),
    .st_op      (st_op),
    .st_rs1     (st_rs1),
    .st_rs2     (st_rs2),
    .st_rs3     (st_rs3),
    .st_count   (st_count),
    .st_acc     (st_acc),
    .st_arg_0   (st_arg_0),
    .st_arg_1   (st_arg_1),
    .st_n_acc   (st_n_acc),
    .st_n_arg_0 (st_n_arg_0),
    .st_n_arg_1 (st_n_arg_1),
    .st_ready   (st_ready),
    .st_result  (st_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Presents a request for one cycle; returns in cycle 1 (first RUN cycle).
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_rs3   = c;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    // Values held while reset is asserted.
    #2;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_st_valid", 64'(st_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_count", 64'(st_count), 64'd0);
    tick(2);
    reset = 1'b0;
    tick();

    // Completion at count 31, then response backpressure.
    ready_en = 1'b1;
    ready_at = 6'd31;
    res_val  = 64'h0000_0001_FFFF_FFFE;
    start_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0011);
    check("run_st_valid", 64'(st_valid), 64'd1);
    check("run_count0", 64'(st_count), 64'd0);
    check("run_acc0", st_acc, 64'd0);
    check("run_op", 64'(st_op), 64'(OP_MUL));
    check("run_rs1", 64'(st_rs1), 64'h1234_5678);
    check("run_rs2", 64'(st_rs2), 64'h9ABC_DEF0);
    check("run_rs3", 64'(st_rs3), 64'h11);
    check("run_req_ready", 64'(req_ready), 64'd0);
    tick(31);
    check("c32_count", 64'(st_count), 64'd31);
    check("c32_acc", st_acc, 64'd93);
    check("c32_arg0", 64'(st_arg_0), 64'd31);
    check("c32_arg1", 64'(st_arg_1), 64'd62);
    check("c32_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("c33_rsp_valid", 64'(rsp_valid), 64'd1);
    check("c33_rsp_result", rsp_result, 64'h0000_0001_FFFF_FFFE);
    check("c33_rsp_error", 64'(rsp_error), 64'd0);
    check("c33_st_valid", 64'(st_valid), 64'd0);
    check("c33_acc_held", st_acc, 64'd93);
    res_val = 64'hDEAD_BEEF_0000_0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_rsp_result", rsp_result, 64'h0000_0001_FFFF_FFFE);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("hs_rsp_valid", 64'(rsp_valid), 64'd0);
    check("hs_req_ready", 64'(req_ready), 64'd1);

    // Minimum latency: ready at count 0 gives rsp_valid two cycles after accept.
    ready_at = 6'd0;
    res_val  = 64'h0000_0000_0000_00A5;
    start_op(OP_DIVU, 32'd100, 32'd7, 32'd0);
    check("min_c1_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("min_c2_rsp_valid", 64'(rsp_valid), 64'd1);
    check("min_c2_result", rsp_result, 64'hA5);
    tick();
    check("min_done_req_ready", 64'(req_ready), 64'd1);

    // Asynchronous reset mid-RUN at count 12.
    ready_en = 1'b0;
    start_op(OP_REM, 32'hFFFF_0000, 32'h0000_FFFF, 32'h5);
    tick(12);
    check("pre_rst_count", 64'(st_count), 64'd12);
    reset = 1'b1;
    #1;
    check("arst_st_valid", 64'(st_valid), 64'd0);
    check("arst_count", 64'(st_count), 64'd0);
    check("arst_acc", st_acc, 64'd0);
    check("arst_rs1", 64'(st_rs1), 64'd0);
    check("arst_op", 64'(st_op), 64'd0);
    check("arst_rsp_result", rsp_result, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("arst_req_ready", 64'(req_ready), 64'd1);

    // Flush at count 10: one-cycle st_flush, back to IDLE, no response.
    start_op(OP_PMUL, 32'h0F0F_0F0F, 32'h3, 32'h0);
    tick(10);
    check("pre_fl_count", 64'(st_count), 64'd10);
    check("pre_fl_acc", st_acc, 64'd30);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("fl_st_flush", 64'(st_flush), 64'd1);
    check("fl_st_valid", 64'(st_valid), 64'd0);
    check("fl_count", 64'(st_count), 64'd0);
    check("fl_acc", st_acc, 64'd0);
    check("fl_arg0", 64'(st_arg_0), 64'd0);
    check("fl_req_ready", 64'(req_ready), 64'd1);
    tick();
    check("fl_pulse_end", 64'(st_flush), 64'd0);
    tick(3);
    check("fl_no_rsp", 64'(rsp_valid), 64'd0);

    // Request and flush together in IDLE: not accepted.
    flush     = 1'b1;
    req_valid = 1'b1;
    #1;
    check("rf_req_ready", 64'(req_ready), 64'd0);
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rf_st_valid", 64'(st_valid), 64'd0);
    check("rf_idle", 64'(req_ready), 64'd1);

    // Datapath never reports ready.
    start_op(OP_CLMUL, 32'h1, 32'h2, 32'h3);
`ifdef XC_MALU_SEQ_TIMEOUT_EN
    tick(63);
    check("to_c64_count", 64'(st_count), 64'd63);
    check("to_c64_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    check("to_rsp_valid", 64'(rsp_valid), 64'd1);
    check("to_rsp_error", 64'(rsp_error), 64'd1);
    check("to_rsp_result", rsp_result, 64'd0);
    check("to_st_valid", 64'(st_valid), 64'd0);
    tick();
`else
    tick(99);
    check("sat_st_valid", 64'(st_valid), 64'd1);
    check("sat_count", 64'(st_count), 64'd63);
    check("sat_rsp_valid", 64'(rsp_valid), 64'd0);
    check("sat_rsp_error", 64'(rsp_error), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("sat_fl_idle", 64'(req_ready), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
